// File: rtl/clac_pkg.sv
// Shared encodings and cycle constants for the calculator core.
// Ports: none (package only).
// Imported by clac_if, clac_iter_unit and clac_core.
package clac_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_MUL = 2'b10,
        MODE_DIV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CYC_ADDSUB = 1;
    localparam int CYC_MULDIV = 16;
    localparam int CNT_W      = 4;

    // Counter load value: number of CALC cycles minus one.
    function automatic logic [CNT_W-1:0] cyc_last(input mode_e m);
        if (m == MODE_MUL || m == MODE_DIV) begin
            return CNT_W'(CYC_MULDIV - 1);
        end
        return CNT_W'(CYC_ADDSUB - 1);
    endfunction

endpackage

// File: rtl/clac_if.sv
// Register-slave side bundle of the calculator core.
// master: drives ctrl/clac_mode/opcode_a/opcode_b, reads result/busy/done.
// slave : the core; consumes the request, returns result/busy/done.
interface clac_if;
    logic        ctrl;
    logic [1:0]  clac_mode;
    logic [15:0] opcode_a;
    logic [15:0] opcode_b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (
        output ctrl, clac_mode, opcode_a, opcode_b,
        input  result, busy, done
    );

    modport slave (
        input  ctrl, clac_mode, opcode_a, opcode_b,
        output result, busy, done
    );
endinterface

// File: rtl/clac_iter_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// Latency: 16 steps after load; value shows the state after the current step.
// Backpressure: none; the caller decides when to load and step.
// Ports: clk, rst (sync, active-high), load, step, is_div, a, b -> value[31:0].
module clac_iter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] value
);
    // hi/lo form one 32-bit working register:
    //   mul: hi = partial product, lo = remaining multiplier bits
    //   div: hi = partial remainder, lo = dividend bits shifting into quotient
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
    logic        div_q, div_d;

    logic [15:0] hi_nxt, lo_nxt;
    logic [16:0] sum;
    logic [16:0] rem_sh;
    logic [15:0] rem_sub;
    logic        qbit;

    // One iteration of whichever algorithm was latched at load.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : 16'd0)};
        rem_sh  = {hi_q, lo_q[15]};
        qbit    = (rem_sh >= {1'b0, opnd_q});
        // When qbit is set the difference is below 2^16, so 16 bits suffice.
        rem_sub = rem_sh[15:0] - opnd_q;
        hi_nxt  = 16'd0;
        lo_nxt  = 16'd0;
        if (div_q) begin
            // A zero divisor always subtracts, giving all-ones quotient and
            // leaving the dividend as the remainder.
            hi_nxt = qbit ? rem_sub : rem_sh[15:0];
            lo_nxt = {lo_q[14:0], qbit};
        end else begin
            hi_nxt = sum[16:1];
            lo_nxt = {sum[0], lo_q[15:1]};
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        if (load) begin
            hi_d   = 16'd0;
            lo_d   = is_div ? a : b;
            opnd_d = is_div ? b : a;
            div_d  = is_div;
        end else if (step) begin
            hi_d = hi_nxt;
            lo_d = lo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= 16'd0;
            lo_q   <= 16'd0;
            opnd_q <= 16'd0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign value = {hi_nxt, lo_nxt};

endmodule

// File: rtl/clac_core.sv
// Edge-triggered add/sub/mul/div engine with a registered result.
// Latency: 1 cycle add/sub, 16 cycles mul/div, from start edge to done.
// Backpressure: starts during CALC are dropped; a start in DONE chains.
// Ports: hclk, hreset (sync, active-high), bus (clac_if.slave):
//   ctrl, clac_mode, opcode_a, opcode_b in; result, busy, done out.
module clac_core
    import clac_pkg::*;
(
    input  logic  hclk,
    input  logic  hreset,
    clac_if.slave bus
);
    state_e             state_q, state_d;
    logic               ctrl_q, ctrl_d;     // previous-cycle ctrl for edge detect
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    mode_e              mode_q, mode_d;
    logic [31:0]        result_q, result_d;

    logic               start;
    logic               iter_load;
    logic               iter_step;
    logic [31:0]        iter_value;
    logic [31:0]        addsub_value;
    mode_e              req_mode;

    assign req_mode = mode_e'(bus.clac_mode);
    // Held-high ctrl is one start: only the 0->1 transition counts.
    assign start    = bus.ctrl & ~ctrl_q;

    always_comb begin
        if (mode_q == MODE_SUB) begin
            addsub_value = {16'd0, a_q} - {16'd0, b_q};
        end else begin
            addsub_value = {16'd0, a_q} + {16'd0, b_q};
        end
    end

    clac_iter_unit u_iter (
        .clk    (hclk),
        .rst    (hreset),
        .load   (iter_load),
        .step   (iter_step),
        .is_div (req_mode == MODE_DIV),
        .a      (bus.opcode_a),
        .b      (bus.opcode_b),
        .value  (iter_value)
    );

    always_comb begin
        state_d   = state_q;
        ctrl_d    = bus.ctrl;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        result_d  = result_q;
        iter_load = 1'b0;
        iter_step = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d       = bus.opcode_a;
                    b_d       = bus.opcode_b;
                    mode_d    = req_mode;
                    cnt_d     = cyc_last(req_mode);
                    iter_load = 1'b1;
                    state_d   = ST_CALC;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // The iter unit steps every CALC cycle; for add/sub its
                // output is simply not used.
                iter_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (mode_q == MODE_MUL || mode_q == MODE_DIV) begin
                        result_d = iter_value;
                    end else begin
                        result_d = addsub_value;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 1'b0;
            cnt_q    <= '0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            mode_q   <= MODE_ADD;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    // busy/done decode straight from the state flop, so they are registered.
    assign bus.busy   = (state_q == ST_CALC);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_clac_core.sv
module tb_clac_core;

    logic hclk;
    logic hreset;
    int   n_cmp;
    int   n_bad;

    clac_if bus ();

    clac_core dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Drive a request, let one edge sample the start, then drop ctrl.
    task automatic start_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        bus.clac_mode = m;
        bus.opcode_a  = a;
        bus.opcode_b  = b;
        bus.ctrl      = 1'b1;
        tick();
        bus.ctrl      = 1'b0;
    endtask

    // Bounded wait for done; cycles reaches 40 on timeout.
    task automatic wait_done(output int cycles, output int busy_cyc, output bit stable);
        logic [31:0] r0;
        r0       = bus.result;
        cycles   = 0;
        busy_cyc = bus.busy ? 1 : 0;
        stable   = 1'b1;
        while (cycles < 40) begin
            tick();
            cycles++;
            if (bus.busy) begin
                busy_cyc++;
                if (bus.result !== r0) stable = 1'b0;
            end
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        bus.ctrl = 1'b0;
        bus.clac_mode = 2'b00;
        bus.opcode_a = 16'd0;
        bus.opcode_b = 16'd0;
        tick();
        tick();
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'd0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        hreset = 1'b0;
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_add();
        int c, bc; bit st;
        start_op(2'b00, 16'hFFFF, 16'h0001);
        wait_done(c, bc, st);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL add_latency: got %0d expected 1", c); end
        n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL add_busy_cycles: got %0d expected 1", bc); end
        n_cmp++; if (bus.result !== 32'h0001_0000) begin n_bad++; $display("FAIL add_result: got %h expected %h", bus.result, 32'h0001_0000); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_sub();
        int c, bc; bit st;
        start_op(2'b01, 16'd3, 16'd5);
        wait_done(c, bc, st);
        n_cmp++; if (bus.result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_neg: got %h expected %h", bus.result, 32'hFFFF_FFFE); end
        tick();
        start_op(2'b01, 16'd5, 16'd3);
        wait_done(c, bc, st);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL sub_latency: got %0d expected 1", c); end
        n_cmp++; if (bus.result !== 32'h0000_0002) begin n_bad++; $display("FAIL sub_pos: got %h expected %h", bus.result, 32'h0000_0002); end
        tick();
    endtask

    task automatic test_mul();
        int c, bc; bit st;
        start_op(2'b10, 16'hFFFF, 16'hFFFF);
        wait_done(c, bc, st);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL mul_latency: got %0d expected 16", c); end
        n_cmp++; if (bc !== 16) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d expected 16", bc); end
        n_cmp++; if (bus.result !== 32'hFFFE_0001) begin n_bad++; $display("FAIL mul_max: got %h expected %h", bus.result, 32'hFFFE_0001); end
        tick();
        start_op(2'b10, 16'h0000, 16'h1234);
        wait_done(c, bc, st);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL mul_result_stable: got %b expected 1", st); end
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL mul_zero: got %h expected %h", bus.result, 32'd0); end
        tick();
    endtask

    task automatic test_div();
        int c, bc; bit st;
        start_op(2'b11, 16'd100, 16'd7);
        wait_done(c, bc, st);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL div_latency: got %0d expected 16", c); end
        n_cmp++; if (bus.result !== 32'h0002_000E) begin n_bad++; $display("FAIL div_100_7: got %h expected %h", bus.result, 32'h0002_000E); end
        tick();
        start_op(2'b11, 16'h1234, 16'h0000);
        wait_done(c, bc, st);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL div0_latency: got %0d expected 16", c); end
        n_cmp++; if (bus.result !== 32'h1234_FFFF) begin n_bad++; $display("FAIL div_by_zero: got %h expected %h", bus.result, 32'h1234_FFFF); end
        tick();
    endtask

    task automatic test_ignore_mid_op();
        int dones; logic [31:0] r_at_done;
        dones = 0;
        r_at_done = 32'hDEAD_BEEF;
        start_op(2'b10, 16'd3, 16'd5);
        bus.opcode_a  = 16'd7;
        bus.opcode_b  = 16'd9;
        bus.clac_mode = 2'b00;
        tick();
        tick();
        bus.ctrl = 1'b1;
        tick();
        tick();
        bus.ctrl = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                r_at_done = bus.result;
            end
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        n_cmp++; if (r_at_done !== 32'd15) begin n_bad++; $display("FAIL ignore_product: got %h expected %h", r_at_done, 32'd15); end
    endtask

    task automatic test_hold_high();
        int dones, bc;
        dones = 0;
        bc = 0;
        bus.clac_mode = 2'b00;
        bus.opcode_a  = 16'd2;
        bus.opcode_b  = 16'd3;
        bus.ctrl      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done) dones++;
            if (bus.busy) bc++;
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL hold_done_count: got %0d expected 1", dones); end
        n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL hold_busy_cycles: got %0d expected 1", bc); end
        n_cmp++; if (bus.result !== 32'd5) begin n_bad++; $display("FAIL hold_result: got %h expected %h", bus.result, 32'd5); end
        bus.ctrl = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int c, bc; bit st;
        bus.clac_mode = 2'b00;
        bus.opcode_a  = 16'd1;
        bus.opcode_b  = 16'd1;
        bus.ctrl      = 1'b1;
        tick();
        bus.ctrl = 1'b0;
        tick();
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
        n_cmp++; if (bus.result !== 32'd2) begin n_bad++; $display("FAIL b2b_first_result: got %h expected %h", bus.result, 32'd2); end
        bus.ctrl      = 1'b1;
        bus.clac_mode = 2'b10;
        bus.opcode_a  = 16'd6;
        bus.opcode_b  = 16'd7;
        tick();
        bus.ctrl = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_done: got %b expected 0", bus.done); end
        wait_done(c, bc, st);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 16", c); end
        n_cmp++; if (bus.result !== 32'd42) begin n_bad++; $display("FAIL b2b_second_result: got %h expected %h", bus.result, 32'd42); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int dones;
        dones = 0;
        start_op(2'b10, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 7; i++) tick();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL midrst_result: got %h expected %h", bus.result, 32'd0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL midrst_result_after: got %h expected %h", bus.result, 32'd0); end
    endtask

    task automatic test_ctrl_through_reset();
        bus.clac_mode = 2'b00;
        bus.opcode_a  = 16'd10;
        bus.opcode_b  = 16'd20;
        bus.ctrl      = 1'b1;
        hreset        = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
        tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rel_start_busy: got %b expected 1", bus.busy); end
        tick();
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rel_done: got %b expected 1", bus.done); end
        n_cmp++; if (bus.result !== 32'd30) begin n_bad++; $display("FAIL rel_result: got %h expected %h", bus.result, 32'd30); end
        bus.ctrl = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_ignore_mid_op();
        test_hold_high();
        test_back_to_back();
        test_reset_mid_op();
        test_ctrl_through_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
